// File: rtl/smpc_pad_pkg.sv
// smpc_pad_reader shared types and constants.
// States, peripheral IDs, header codes and pin direction mask.
package smpc_pad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_DIG,
    S_DIG_WR,
    S_HS_SET,
    S_HS_POLL,
    S_FINISH
  } state_t;

  localparam logic [7:0] ID_NONE    = 8'hFF;
  localparam logic [7:0] ID_DIGITAL = 8'h02;
  localparam logic [3:0] HDR_SATURN = 4'h1;
  localparam logic [3:0] HDR_MD3W   = 4'hB;
  localparam logic [6:0] DDR_TH_TR  = 7'h60;

  // Saturn digital pad answers TH=TR=1 with data 'x100'.
  function automatic logic is_digital(input logic [3:0] d);
    return d[2:0] == 3'b100;
  endfunction

endpackage

// File: rtl/smpc_pad_nibble_pack.sv
// Nibble-to-byte assembler feeding the payload byte buffer.
// High half first; byte write strobes on every second nibble.
module smpc_pad_nibble_pack
  import smpc_pad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic [3:0] nib,
  output logic       we,
  output logic [3:0] addr,
  output logic [7:0] data,
  output logic [3:0] count
);

  logic [3:0] hi;
  logic       half;

  // Pair nibbles into bytes and issue one-clock write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= 4'h0;
      half  <= 1'b0;
      we    <= 1'b0;
      addr  <= 4'h0;
      data  <= 8'h00;
      count <= 4'h0;
    end else if (clr) begin
      hi    <= 4'h0;
      half  <= 1'b0;
      we    <= 1'b0;
      addr  <= 4'h0;
      count <= 4'h0;
    end else begin
      we <= 1'b0;
      if (push) begin
        if (!half) begin
          hi   <= nib;
          half <= 1'b1;
        end else begin
          we    <= 1'b1;
          data  <= {hi, nib};
          addr  <= count;
          count <= count + 4'd1;
          half  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/smpc_pad_reader.sv
// SMPC controller-port acquisition engine (digital / 3-wire / MD).
// Optional TL handshake timeout: define SMPC_PAD_TIMEOUT_EN.
module smpc_pad_reader
  import smpc_pad_pkg::*;
#(
  parameter int         SETTLE  = 1,
  parameter logic [7:0] MD3W_ID = 8'hE3
`ifdef SMPC_PAD_TIMEOUT_EN
  ,
  parameter int         TIMEOUT = 255
`endif
)(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       START,
  input  logic [6:0] PDRI,
  output logic [6:0] PDRO,
  output logic [6:0] DDR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] PERI_ID,
  output logic [3:0] PERI_LEN,
  output logic       BUF_WE,
  output logic [3:0] BUF_ADDR,
  output logic [7:0] BUF_DATA
);

  state_t     state, state_n;
  logic [7:0] cnt;
  logic [1:0] step;
  logic [1:0] k;
  logic [3:0] n00, n01, n10;
  logic       n11_l;
  logic [3:0] h0, h1;
  logic [4:0] rem;
  logic       tr;
  logic [7:0] id_q;
  logic [1:0] pdr;
  logic       busy, done;
  logic       push;
  logic [3:0] pnib;
  logic       tmo_hit;

  logic [3:0] nib;
  logic       settled, tl_ok, start_ok;
  logic       hdr_sat, hdr_md, hs_last;
  logic       unused_pins;

  assign nib         = PDRI[3:0];
  assign settled     = cnt == 8'd0;
  assign tl_ok       = PDRI[4] == tr;
  assign start_ok    = CE && START && state == S_IDLE;
  assign hdr_sat     = h0 == HDR_SATURN;
  assign hdr_md      = h0 == HDR_MD3W;
  assign unused_pins = ^PDRI[6:5];

  // Last nibble: bad header, empty Saturn payload, or final payload.
  assign hs_last =
    (k == 2'd2 && (!(hdr_sat || hdr_md) ||
                   (hdr_sat && nib == 4'h0))) ||
    (k == 2'd3 && rem == 5'd1);

`ifdef SMPC_PAD_TIMEOUT_EN
  logic [15:0] tmo;
  logic        err_q;

  assign tmo_hit = tmo == 16'(TIMEOUT - 1);
  assign ERR     = err_q;

  // Count CE ticks spent waiting for TL to follow TR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo   <= 16'd0;
      err_q <= 1'b0;
    end else if (CE) begin
      if (start_ok) begin
        tmo   <= 16'd0;
        err_q <= 1'b0;
      end else if (state == S_HS_POLL) begin
        if (tl_ok) begin
          tmo <= 16'd0;
        end else begin
          tmo <= tmo + 16'd1;
          if (tmo_hit) err_q <= 1'b1;
        end
      end else begin
        tmo <= 16'd0;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode; everything advances on CE only.
  always_comb begin
    state_n = state;
    if (CE) begin
      unique case (state)
        S_IDLE:
          if (START) state_n = S_PROBE;
        S_PROBE:
          if (settled) begin
            if (is_digital(nib))  state_n = S_DIG;
            else if (nib == 4'hF) state_n = S_FINISH;
            else                  state_n = S_HS_SET;
          end
        S_DIG:
          if (settled && step == 2'd3) state_n = S_DIG_WR;
        S_DIG_WR:
          if (step == 2'd3) state_n = S_FINISH;
        S_HS_SET:
          if (settled) state_n = S_HS_POLL;
        S_HS_POLL:
          if (tl_ok)        state_n = hs_last ? S_FINISH : S_HS_SET;
          else if (tmo_hit) state_n = S_FINISH;
        S_FINISH:
          state_n = S_IDLE;
        default:
          state_n = S_IDLE;
      endcase
    end
  end

  // Settle timing, nibble capture, header parse and ID tracking.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= 8'd0;
      step  <= 2'd0;
      k     <= 2'd0;
      n00   <= 4'h0;
      n01   <= 4'h0;
      n10   <= 4'h0;
      n11_l <= 1'b0;
      h0    <= 4'h0;
      h1    <= 4'h0;
      rem   <= 5'd0;
      tr    <= 1'b1;
      id_q  <= ID_NONE;
    end else if (CE) begin
      case (state)
        S_IDLE:
          if (START) begin
            cnt  <= 8'(SETTLE);
            id_q <= ID_NONE;
            tr   <= 1'b1;
            step <= 2'd0;
            k    <= 2'd0;
          end
        S_PROBE:
          if (!settled) begin
            cnt <= cnt - 8'd1;
          end else begin
            cnt  <= 8'(SETTLE);
            step <= 2'd0;
          end
        S_DIG:
          if (!settled) begin
            cnt <= cnt - 8'd1;
          end else begin
            case (step)
              2'd0: n00   <= nib;
              2'd1: n01   <= nib;
              2'd2: n10   <= nib;
              2'd3: n11_l <= nib[3];
            endcase
            if (step == 2'd3) id_q <= ID_DIGITAL;
            step <= step + 2'd1;
            cnt  <= 8'(SETTLE);
          end
        S_DIG_WR:
          step <= step + 2'd1;
        S_HS_SET:
          if (!settled) cnt <= cnt - 8'd1;
        S_HS_POLL:
          if (tl_ok) begin
            tr  <= ~tr;
            cnt <= 8'(SETTLE);
            case (k)
              2'd0: begin
                h0 <= nib;
                k  <= 2'd1;
              end
              2'd1: begin
                h1 <= nib;
                k  <= 2'd2;
              end
              2'd2: begin
                k    <= 2'd3;
                rem  <= hdr_md ? 5'd6 : {nib, 1'b0};
                id_q <= hdr_sat ? {h1, nib} :
                        hdr_md  ? MD3W_ID : ID_NONE;
              end
              default:
                rem <= rem - 5'd1;
            endcase
          end else if (tmo_hit) begin
            id_q <= ID_NONE;
          end
        default: ;
      endcase
    end
  end

  // Nibble stream into the byte assembler.
  always_comb begin
    push = 1'b0;
    pnib = nib;
    if (CE && state == S_DIG_WR) begin
      push = 1'b1;
      case (step)
        2'd0: pnib = n01;
        2'd1: pnib = n10;
        2'd2: pnib = n00;
        2'd3: pnib = {n11_l, 3'b111};
      endcase
    end else if (CE && state == S_HS_POLL &&
                 tl_ok && k == 2'd3) begin
      push = 1'b1;
    end
  end

  // Pin drive and status outputs.
  always_comb begin
    pdr  = 2'b11;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_PROBE, S_DIG_WR:
        busy = 1'b1;
      S_DIG: begin
        pdr  = step;
        busy = 1'b1;
      end
      S_HS_SET, S_HS_POLL: begin
        pdr  = {1'b0, tr};
        busy = 1'b1;
      end
      S_FINISH:
        done = CE;
      default: ;
    endcase
  end

  assign PDRO    = {pdr, 5'b00000};
  assign DDR     = DDR_TH_TR;
  assign BUSY    = busy;
  assign DONE    = done;
  assign PERI_ID = id_q;

  smpc_pad_nibble_pack u_pack (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (start_ok),
    .push  (push),
    .nib   (pnib),
    .we    (BUF_WE),
    .addr  (BUF_ADDR),
    .data  (BUF_DATA),
    .count (PERI_LEN)
  );

endmodule

// File: tb/tb_smpc_pad_reader.sv
// Directed bench for smpc_pad_reader with pad/3-wire/mouse models.
// CE runs two of every three clocks.
module tb_smpc_pad_reader;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CE = 1'b0;
  logic       START = 1'b0;
  logic [6:0] PDRI;
  logic [6:0] PDRO;
  logic [6:0] DDR;
  logic       BUSY, DONE, ERR, BUF_WE;
  logic [7:0] PERI_ID;
  logic [3:0] PERI_LEN;
  logic [3:0] BUF_ADDR;
  logic [7:0] BUF_DATA;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  smpc_pad_reader dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE       (CE),
    .START    (START),
    .PDRI     (PDRI),
    .PDRO     (PDRO),
    .DDR      (DDR),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .PERI_ID  (PERI_ID),
    .PERI_LEN (PERI_LEN),
    .BUF_WE   (BUF_WE),
    .BUF_ADDR (BUF_ADDR),
    .BUF_DATA (BUF_DATA)
  );

  always #5 CLK = ~CLK;

  int cec = 0;
  always @(posedge CLK) begin
    #1;
    cec = cec + 1;
    CE = (cec % 3) != 0;
  end

  // Device models
  int         mode = 0;
  logic [3:0] probe_nib = 4'h0;
  logic [3:0] nibs [32];
  logic [3:0] dig [4];
  int         k = 0;
  logic       prev_th = 1'b1;
  logic       prev_tr = 1'b1;
  logic [3:0] rdata = 4'h0;
  logic       rtl = 1'b1;

  always @(negedge CLK) begin
    if (!PDRO[6]) begin
      if (prev_th) k = 0;
      else if (PDRO[5] != prev_tr && k < 31) k = k + 1;
      rdata = nibs[k];
      rtl   = PDRO[5];
    end else begin
      rdata = probe_nib;
      rtl   = 1'b1;
    end
    prev_th = PDRO[6];
    prev_tr = PDRO[5];
  end

  assign PDRI = (mode == 0) ? 7'h7F :
                (mode == 1) ? {PDRO[6:5], 1'b1, dig[PDRO[6:5]]} :
                              {PDRO[6:5], rtl, rdata};

  // Output monitor
  int         done_cnt = 0;
  int         we_cnt = 0;
  logic [7:0] bufm [16];
  logic       err_d = 1'b0;
  logic [7:0] id_d = 8'h00;
  logic [3:0] len_d = 4'h0;
  logic [7:0] pdr_log = 8'h00;
  int         pdr_n = 0;
  logic [1:0] pdr_last = 2'b11;

  always @(negedge CLK) begin
    if (DONE) begin
      done_cnt = done_cnt + 1;
      err_d    = ERR;
      id_d     = PERI_ID;
      len_d    = PERI_LEN;
    end
    if (BUF_WE) begin
      bufm[BUF_ADDR] = BUF_DATA;
      we_cnt = we_cnt + 1;
    end
    if (PDRO[6:5] !== pdr_last) begin
      pdr_log  = {pdr_log[5:0], PDRO[6:5]};
      pdr_n    = pdr_n + 1;
      pdr_last = PDRO[6:5];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic load(input logic [63:0] v, input int n);
    for (int i = 0; i < 32; i++) nibs[i] = 4'h0;
    for (int i = 0; i < n; i++) nibs[i] = v[4*(n-1-i) +: 4];
  endtask

  task automatic run(input string tag, input bit extra);
    int d0;
    int n;
    d0 = done_cnt;
    START = 1'b1;
    n = 0;
    while (!BUSY && done_cnt == d0 && n < 20) begin
      tick();
      n++;
    end
    START = 1'b0;
    if (extra) begin
      repeat (6) tick();
      START = 1'b1;
      repeat (4) tick();
      START = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  int w0, p0, d1, n;

  initial begin
    for (int i = 0; i < 16; i++) bufm[i] = 8'hAA;
    load(64'h0, 0);
    dig[0] = 4'hF; dig[1] = 4'hF; dig[2] = 4'hF; dig[3] = 4'hC;
    repeat (3) tick();
    chk("rst_pdro", PDRO, 7'h60);
    chk("rst_ddr", DDR, 7'h60);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_we", BUF_WE, 0);
    chk("rst_id", PERI_ID, 8'hFF);
    chk("rst_len", PERI_LEN, 0);
    chk("rst_addr", BUF_ADDR, 0);
    RST_N = 1'b1;
    repeat (2) tick();

    // Digital pad, no buttons
    mode = 1;
    w0 = we_cnt; p0 = pdr_n;
    run("dig1", 1'b0);
    chk("dig1_id", id_d, 8'h02);
    chk("dig1_len", len_d, 2);
    chk("dig1_err", err_d, 0);
    chk("dig1_b0", bufm[0], 8'hFF);
    chk("dig1_b1", bufm[1], 8'hFF);
    chk("dig1_we", we_cnt - w0, 2);
    chk("dig1_pdr_n", pdr_n - p0, 4);
    chk("dig1_pdr_seq", pdr_log, 8'h1B);
    chk("dig1_pdro_end", PDRO, 7'h60);

    // Digital pad, distinct nibbles
    dig[0] = 4'h3; dig[1] = 4'h5; dig[2] = 4'hA; dig[3] = 4'h4;
    w0 = we_cnt;
    run("dig2", 1'b0);
    chk("dig2_b0", bufm[0], 8'h5A);
    chk("dig2_b1", bufm[1], 8'h37);
    chk("dig2_we", we_cnt - w0, 2);

    // 3D pad, with a stray START mid-acquisition
    mode = 2; probe_nib = 4'h1;
    load(64'h116123400005678, 15);
    w0 = we_cnt; d1 = done_cnt;
    run("pad3d", 1'b1);
    repeat (30) tick();
    chk("pad3d_one_done", done_cnt - d1, 1);
    chk("pad3d_idle", BUSY, 0);
    chk("pad3d_id", id_d, 8'h16);
    chk("pad3d_len", len_d, 6);
    chk("pad3d_err", err_d, 0);
    chk("pad3d_b0", bufm[0], 8'h12);
    chk("pad3d_b1", bufm[1], 8'h34);
    chk("pad3d_b2", bufm[2], 8'h00);
    chk("pad3d_b3", bufm[3], 8'h00);
    chk("pad3d_b5", bufm[5], 8'h78);
    chk("pad3d_we", we_cnt - w0, 6);
    chk("pad3d_pdro_end", PDRO, 7'h60);

    // Mega Drive-type mouse
    probe_nib = 4'h0;
    load(64'hBFF0F1234, 9);
    w0 = we_cnt;
    run("mouse", 1'b0);
    chk("mouse_id", id_d, 8'hE3);
    chk("mouse_len", len_d, 3);
    chk("mouse_b0", bufm[0], 8'h0F);
    chk("mouse_b1", bufm[1], 8'h12);
    chk("mouse_b2", bufm[2], 8'h34);
    chk("mouse_we", we_cnt - w0, 3);

    // Nothing connected
    mode = 0;
    w0 = we_cnt;
    run("none", 1'b0);
    chk("none_id", id_d, 8'hFF);
    chk("none_len", len_d, 0);
    chk("none_err", err_d, 0);
    chk("none_we", we_cnt - w0, 0);

    // Unknown header
    mode = 2;
    load(64'h234, 3);
    w0 = we_cnt;
    run("badhdr", 1'b0);
    chk("badhdr_id", id_d, 8'hFF);
    chk("badhdr_len", len_d, 0);
    chk("badhdr_we", we_cnt - w0, 0);

    // Saturn header with empty payload
    load(64'h120, 3);
    w0 = we_cnt;
    run("sat0", 1'b0);
    chk("sat0_id", id_d, 8'h20);
    chk("sat0_len", len_d, 0);
    chk("sat0_we", we_cnt - w0, 0);

    // Reset during payload nibble 5
    probe_nib = 4'h1;
    load(64'h116123400005678, 15);
    d1 = done_cnt;
    START = 1'b1;
    n = 0;
    while (!BUSY && n < 20) begin
      tick();
      n++;
    end
    START = 1'b0;
    n = 0;
    while (k != 8 && n < 2000) begin
      tick();
      n++;
    end
    chk("mid_reached_nib5", k, 8);
    RST_N = 1'b0;
    #1;
    chk("mid_pdro", PDRO, 7'h60);
    chk("mid_busy", BUSY, 0);
    chk("mid_done", DONE, 0);
    chk("mid_id", PERI_ID, 8'hFF);
    chk("mid_len", PERI_LEN, 0);
    chk("mid_addr", BUF_ADDR, 0);
    chk("mid_we", BUF_WE, 0);
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (10) tick();
    chk("mid_no_done", done_cnt - d1, 0);
    probe_nib = 4'h0;
    load(64'hBFF0F1234, 9);
    run("after_rst", 1'b0);
    chk("after_rst_id", id_d, 8'hE3);
    chk("after_rst_len", len_d, 3);
    chk("after_rst_b2", bufm[2], 8'h34);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
